// File: rtl/program_memory_loader.sv
// Program memory writer: packs UART bytes into instruction words (MSB byte first),
// writes them at consecutive word addresses from 0 and holds the pipeline in reset
// until a HALT word is stored or the memory fills up.
module program_memory_loader #(
   parameter int unsigned            NB_INSTRUC        = 32,
   parameter int unsigned            NB_ADDR           = 32,
   parameter int unsigned            NB_BYTE           = 8,
   parameter int unsigned            RAM_DEPTH_PROGRAM = 2048,
   parameter logic [NB_BYTE-1:0]     CMD_LOAD          = NB_BYTE'(8'h4C),
   parameter logic [NB_INSTRUC-1:0]  HALT_WORD         = {NB_INSTRUC{1'b1}}
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic [NB_BYTE-1:0]    i_rx_data,
   input  logic                  i_rx_done,
   output logic                  o_wr_en,
   output logic [NB_ADDR-1:0]    o_wr_addr,
   output logic [NB_INSTRUC-1:0] o_wr_data,
   output logic                  o_cpu_rst,
   output logic                  o_load_done,
   output logic                  o_overflow
);

   localparam int unsigned BYTES_PER_WORD = NB_INSTRUC / NB_BYTE;
   localparam int unsigned NB_CNT         = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
   localparam logic [NB_CNT-1:0]  LAST_BYTE = NB_CNT'(BYTES_PER_WORD - 1);
   localparam logic [NB_ADDR-1:0] LAST_ADDR = NB_ADDR'(RAM_DEPTH_PROGRAM - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RECV  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t                  state, state_nxt;
   logic [NB_CNT-1:0]       byte_cnt, byte_cnt_nxt;
   logic [NB_ADDR-1:0]      addr, addr_nxt;
   logic [NB_INSTRUC-1:0]   word, word_nxt;
   logic [NB_INSTRUC-1:0]   word_shift;
   logic                    wr_en_nxt;
   logic [NB_ADDR-1:0]      wr_addr_nxt;
   logic [NB_INSTRUC-1:0]   wr_data_nxt;
   logic                    cpu_rst_nxt;
   logic                    load_done_nxt;
   logic                    overflow_nxt;

   // Incoming byte appended at the LSB end so the first byte ends up as the MSB.
   assign word_shift = {word[NB_INSTRUC-NB_BYTE-1:0], i_rx_data};

   // State, assembly and registered output update.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state       <= IDLE;
         byte_cnt    <= '0;
         addr        <= '0;
         word        <= '0;
         o_wr_en     <= 1'b0;
         o_wr_addr   <= '0;
         o_wr_data   <= '0;
         o_cpu_rst   <= 1'b0;
         o_load_done <= 1'b0;
         o_overflow  <= 1'b0;
      end else begin
         state       <= state_nxt;
         byte_cnt    <= byte_cnt_nxt;
         addr        <= addr_nxt;
         word        <= word_nxt;
         o_wr_en     <= wr_en_nxt;
         o_wr_addr   <= wr_addr_nxt;
         o_wr_data   <= wr_data_nxt;
         o_cpu_rst   <= cpu_rst_nxt;
         o_load_done <= load_done_nxt;
         o_overflow  <= overflow_nxt;
      end
   end

   // Next state and next output values; outputs are computed one cycle ahead so the
   // registered write pulse lines up with the WRITE state.
   always_comb begin
      state_nxt     = state;
      byte_cnt_nxt  = byte_cnt;
      addr_nxt      = addr;
      word_nxt      = word;
      wr_en_nxt     = 1'b0;
      wr_addr_nxt   = o_wr_addr;
      wr_data_nxt   = o_wr_data;
      cpu_rst_nxt   = 1'b0;
      load_done_nxt = 1'b0;
      overflow_nxt  = o_overflow;

      case (state)
         IDLE: begin
            if (i_rx_done && (i_rx_data == CMD_LOAD)) begin
               state_nxt    = RECV;
               addr_nxt     = '0;
               byte_cnt_nxt = '0;
            end
         end

         RECV: begin
            if (i_rx_done) begin
               word_nxt     = word_shift;
               byte_cnt_nxt = byte_cnt + NB_CNT'(1);
               if (byte_cnt == LAST_BYTE) begin
                  state_nxt   = WRITE;
                  wr_en_nxt   = 1'b1;
                  wr_addr_nxt = addr;
                  wr_data_nxt = word_shift;
               end
            end
         end

         WRITE: begin
            // Overflow is judged before the increment, so the address never wraps.
            if (word == HALT_WORD) begin
               state_nxt     = DONE;
               cpu_rst_nxt   = 1'b1;
               load_done_nxt = 1'b1;
            end else if (addr == LAST_ADDR) begin
               state_nxt     = DONE;
               overflow_nxt  = 1'b1;
               cpu_rst_nxt   = 1'b1;
               load_done_nxt = 1'b1;
            end else begin
               state_nxt    = RECV;
               addr_nxt     = addr + NB_ADDR'(1);
               byte_cnt_nxt = '0;
            end
         end

         DONE: begin
            cpu_rst_nxt   = 1'b1;
            load_done_nxt = 1'b1;
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_program_memory_loader.sv
// Bench for program_memory_loader: directed and random load sessions compared against
// a byte-stream reference model of the loader protocol.
module tb_program_memory_loader;

   localparam int unsigned DEPTH = 4;
   localparam logic [31:0] HALT  = 32'hFFFF_FFFF;
   localparam logic [7:0]  CMD   = 8'h4C;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      time         t;
   } wr_t;

   logic        clk;
   logic        rst_n;
   logic [7:0]  rx_data;
   logic        rx_done;
   logic        wr_en;
   logic [31:0] wr_addr;
   logic [31:0] wr_data;
   logic        cpu_rst;
   logic        load_done;
   logic        overflow;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] tx_q[$];
   time        tx_t[$];
   wr_t        wr_log[$];
   wr_t        exp_q[$];
   bit         exp_fin;
   bit         exp_ovf;
   bit         done_seen;
   time        done_time;
   logic       prev_wr_en;

   program_memory_loader #(
      .RAM_DEPTH_PROGRAM(DEPTH)
   ) dut (
      .i_clk       (clk),
      .i_rst       (rst_n),
      .i_rx_data   (rx_data),
      .i_rx_done   (rx_done),
      .o_wr_en     (wr_en),
      .o_wr_addr   (wr_addr),
      .o_wr_data   (wr_data),
      .o_cpu_rst   (cpu_rst),
      .o_load_done (load_done),
      .o_overflow  (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Observe the write port and the load-done rise away from the active edge.
   always @(negedge clk) begin
      if (wr_en) begin
         wr_log.push_back('{addr: wr_addr, data: wr_data, t: $time});
         check("wr_pulse_width", 64'(prev_wr_en), 64'd0);
      end
      if (load_done && !done_seen) begin
         done_seen = 1'b1;
         done_time = $time;
      end
      prev_wr_en = wr_en;
   end

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      wr_log.delete();
      tx_t.delete();
      done_seen = 1'b0;
      repeat (4) begin
         rx_done = 1'($urandom);
         rx_data = 8'($urandom);
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      check("rst_wr_en",     64'(wr_en),     64'd0);
      check("rst_wr_addr",   64'(wr_addr),   64'd0);
      check("rst_wr_data",   64'(wr_data),   64'd0);
      check("rst_cpu_rst",   64'(cpu_rst),   64'd0);
      check("rst_load_done", 64'(load_done), 64'd0);
      check("rst_overflow",  64'(overflow),  64'd0);
      check("rst_no_writes", 64'(wr_log.size()), 64'd0);
      @(posedge clk);
      #1;
      rx_done = 1'b0;
      rst_n   = 1'b1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(posedge clk);
      #1;
      rx_data = b;
      rx_done = 1'b1;
      @(posedge clk);
      tx_t.push_back($time);
      #1;
      rx_done = 1'b0;
      rx_data = 8'($urandom);
      repeat ($urandom_range(0, 2)) @(posedge clk);
   endtask

   // Reference: ignore bytes until the load command, then every 4 bytes form one word
   // written at the next address; HALT or the last address ends the session.
   task automatic build_expect();
      bit          started = 1'b0;
      int          nbytes  = 0;
      logic [31:0] w       = '0;
      int unsigned a       = 0;
      exp_q.delete();
      exp_fin = 1'b0;
      exp_ovf = 1'b0;
      for (int i = 0; i < tx_q.size(); i++) begin
         if (exp_fin) continue;
         if (!started) begin
            started = (tx_q[i] == CMD);
            continue;
         end
         w = (w << 8) | 32'(tx_q[i]);
         nbytes++;
         if (nbytes == 4) begin
            exp_q.push_back('{addr: a, data: w, t: tx_t[i] + 5});
            nbytes = 0;
            if (w == HALT) exp_fin = 1'b1;
            else if (a == DEPTH - 1) begin
               exp_fin = 1'b1;
               exp_ovf = 1'b1;
            end else a++;
         end
      end
   endtask

   task automatic run_session(input string name);
      do_reset();
      foreach (tx_q[i]) send_byte(tx_q[i]);
      repeat (4) @(posedge clk);
      @(negedge clk);
      build_expect();
      check({name, "_wr_count"}, 64'(wr_log.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < wr_log.size(); i++) begin
         check({name, "_wr_addr"}, 64'(wr_log[i].addr), 64'(exp_q[i].addr));
         check({name, "_wr_data"}, 64'(wr_log[i].data), 64'(exp_q[i].data));
         check({name, "_wr_time"}, 64'(wr_log[i].t),    64'(exp_q[i].t));
      end
      check({name, "_load_done"}, 64'(load_done), 64'(exp_fin));
      check({name, "_cpu_rst"},   64'(cpu_rst),   64'(exp_fin));
      check({name, "_overflow"},  64'(overflow),  64'(exp_ovf));
      if (exp_fin && exp_q.size() > 0)
         check({name, "_done_time"}, 64'(done_time), 64'(exp_q[exp_q.size()-1].t + 10));
   endtask

   task automatic push_word(input logic [31:0] w);
      tx_q.push_back(w[31:24]);
      tx_q.push_back(w[23:16]);
      tx_q.push_back(w[15:8]);
      tx_q.push_back(w[7:0]);
   endtask

   initial begin
      logic [7:0]  b;
      logic [31:0] w;
      rst_n      = 1'b0;
      rx_done    = 1'b0;
      rx_data    = '0;
      prev_wr_en = 1'b0;
      done_seen  = 1'b0;
      done_time  = 0;

      // basic load ending in HALT
      tx_q.delete();
      tx_q.push_back(CMD);
      push_word(32'h0000_0001);
      push_word(HALT);
      run_session("basic");

      // byte order
      tx_q.delete();
      tx_q.push_back(CMD);
      push_word(32'h1234_5678);
      run_session("order");

      // bytes before the command are ignored
      tx_q.delete();
      tx_q.push_back(8'h00);
      tx_q.push_back(8'h11);
      tx_q.push_back(8'h22);
      tx_q.push_back(CMD);
      push_word(32'h0000_0001);
      push_word(HALT);
      run_session("ignore");

      // overflow: five non-HALT words into a four-word memory
      tx_q.delete();
      tx_q.push_back(CMD);
      for (int i = 0; i < 5; i++) push_word(32'hA000_0000 + 32'(i));
      run_session("overflow");

      // reset two bytes into the second word, then a fresh load from address 0
      tx_q.delete();
      tx_q.push_back(CMD);
      push_word(32'h0102_0304);
      tx_q.push_back(8'h05);
      tx_q.push_back(8'h06);
      run_session("midrst_a");
      tx_q.delete();
      tx_q.push_back(CMD);
      push_word(32'hCAFE_F00D);
      push_word(HALT);
      run_session("midrst_b");

      // random sessions
      for (int s = 0; s < 20; s++) begin
         tx_q.delete();
         repeat ($urandom_range(0, 3)) begin
            b = 8'($urandom);
            if (b == CMD) b = 8'h00;
            tx_q.push_back(b);
         end
         tx_q.push_back(CMD);
         repeat ($urandom_range(1, 6)) begin
            w = ($urandom_range(0, 4) == 0) ? HALT : 32'($urandom);
            push_word(w);
         end
         repeat ($urandom_range(0, 3)) tx_q.push_back(8'($urandom));
         run_session("random");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
